// File: rtl/mem_arbiter_rr_if.sv
// Requester channels and memory port shared by the round-robin memory arbiter.
// The slave view is the arbiter; the master view is the requester/memory side.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 19
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter with burst locking for a single-port memory; one access
// per cycle, read data routed back to the issuing requester one cycle later.
module mem_arbiter_rr #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 19,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_rr_if.slave bus
);
  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [OWN_W-1:0]   rd_id_q, rd_id_d;
  logic [DATA_W-1:0]  rsp_data_q;

  logic [OWN_W-1:0]   sel, cand;
  logic               sel_vld, accept, sel_we, rsp_fire;

  // Owner keeps the port while valid and under its burst budget; otherwise
  // scan starting just past the owner so the owner is considered last.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    if (state_q == OWNED && bus.req_valid[owner_q] && cnt_q < CNT_W'(BURST_MAX)) begin
      sel     = owner_q;
      sel_vld = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = OWN_W'((32'(owner_q) + i) % NUM_REQ);
        if (!sel_vld && bus.req_valid[cand]) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign accept = sel_vld & ~rst;

  always_comb begin
    sel_we        = bus.req_we[0];
    bus.mem_addr  = bus.req_addr[0 +: ADDR_W];
    bus.mem_wdata = bus.req_wdata[0 +: DATA_W];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == OWN_W'(i)) begin
        sel_we        = bus.req_we[i];
        bus.mem_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
    bus.mem_we    = accept & sel_we;
    bus.req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rd_pend_d = accept & ~sel_we;
    rd_id_d   = rd_id_q;
    if (accept) begin
      state_d = OWNED;
      rd_id_d = sel;
      if (state_q == OWNED && sel == owner_q) begin
        cnt_d = (cnt_q == CNT_W'(BURST_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        owner_d = sel;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Response is suppressed while reset is held, so a read accepted just
  // before reset never strobes rsp_valid.
  assign rsp_fire      = rd_pend_q & ~rst;
  assign bus.rsp_valid = rsp_fire ? (NUM_REQ'(1) << rd_id_q) : '0;
  assign bus.rsp_data  = rsp_fire ? bus.mem_rdata : rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_W'(NUM_REQ - 1);
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      if (rd_pend_q) rsp_data_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios then random traffic, all
// checked against a behavioural arbiter and shadow memory.
module tb_mem_arbiter_rr;
  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 19;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter_rr #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory with registered read port
  logic [DW-1:0] mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus
  bit [NR-1:0]   v, w;
  logic [AW-1:0] ad [NR];
  logic [DW-1:0] wd [NR];

  // Reference model state
  logic [DW-1:0] ref_mem [1024] = '{default: '0};
  bit            m_owned = 0;
  int            m_owner = NR - 1;
  int            m_cnt   = 0;
  bit            m_pend  = 0;
  int            m_pid   = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [DW-1:0] m_last  = '0;

  logic [NR-1:0] obs_ready, obs_rv;
  logic [DW-1:0] obs_rd;

  function automatic int model_pick();
    if (rst) return -1;
    if (m_owned && v[m_owner] && m_cnt < BM) return m_owner;
    for (int k = 1; k <= NR; k++)
      if (v[(m_owner + k) % NR]) return (m_owner + k) % NR;
    return -1;
  endfunction

  task automatic model_clock(input int p);
    if (rst) begin
      m_owned = 0; m_owner = NR - 1; m_cnt = 0; m_pend = 0; m_last = '0;
    end else begin
      if (m_pend) m_last = m_pdata;
      m_pend = 0;
      if (p >= 0) begin
        if (m_owned && p == m_owner) m_cnt++;
        else begin m_owner = p; m_cnt = 1; end
        m_owned = 1;
        if (w[p]) ref_mem[ad[p]] = wd[p];
        else begin m_pend = 1; m_pid = p; m_pdata = ref_mem[ad[p]]; end
      end else begin
        m_owned = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic apply();
    bus.req_valid = v;
    bus.req_we    = w;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW]  = ad[i];
      bus.req_wdata[i*DW +: DW] = wd[i];
    end
  endtask

  task automatic step();
    int p;
    logic [NR-1:0] er, ev;
    apply();
    @(negedge clk);
    p  = model_pick();
    er = (p >= 0) ? NR'(1) << p : '0;
    ev = (m_pend && !rst) ? NR'(1) << m_pid : '0;
    chk("req_ready", bus.req_ready, er);
    chk("mem_we", bus.mem_we, (p >= 0) ? w[p] : 1'b0);
    if (p >= 0) chk("mem_addr", bus.mem_addr, ad[p]);
    if (p >= 0 && w[p]) chk("mem_wdata", bus.mem_wdata, wd[p]);
    chk("rsp_valid", bus.rsp_valid, ev);
    chk("rsp_data", bus.rsp_data, (m_pend && !rst) ? m_pdata : m_last);
    obs_ready = bus.req_ready;
    obs_rv    = bus.rsp_valid;
    obs_rd    = bus.rsp_data;
    @(posedge clk);
    model_clock(p);
    #1;
  endtask

  task automatic set_req(input int i, input bit val, input bit we_, input int a, input int d);
    v[i] = val; w[i] = we_; ad[i] = AW'(a); wd[i] = DW'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0;
    step(); step();
    rst = 1'b0;
  endtask

  bit [NR-1:0] seq [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    v = '0; w = '0;
    for (int i = 0; i < NR; i++) begin ad[i] = '0; wd[i] = '0; end
    do_reset();
    chk("rst_rsp_data", bus.rsp_data, 0);

    // Both requesters streaming reads: burst of BM then rotate
    set_req(0, 1, 0, 3, 0);
    set_req(1, 1, 0, 4, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("burst_seq", obs_ready, seq[i]);
    end
    v = '0; step();

    // Write then read-back by same requester
    do_reset();
    set_req(0, 1, 1, 5, 19'h7FFFF); v[1] = 0; step();
    set_req(0, 1, 0, 5, 0); step();
    v = '0; step();
    chk("wr_rd_valid", obs_rv, 2'b01);
    chk("wr_rd_data", obs_rd, 19'h7FFFF);

    // Write by req0 at top address, read by req1 next cycle
    set_req(0, 1, 1, 1023, 19'h12345); v[1] = 0; step();
    v[0] = 0; set_req(1, 1, 0, 1023, 0); step();
    v = '0; step();
    chk("xreq_valid", obs_rv, 2'b10);
    chk("xreq_data", obs_rd, 19'h12345);

    // Owner drops valid mid-burst: other requester granted without a gap
    set_req(1, 1, 0, 7, 0); v[0] = 0; step(); step();
    chk("own_hold", obs_ready, 2'b10);
    set_req(0, 1, 0, 8, 0); v[1] = 0; step();
    chk("own_drop", obs_ready, 2'b01);

    // Reset right after a read accept mid-burst
    v[0] = 0; set_req(1, 1, 0, 1023, 0); step(); step();
    rst = 1'b1; v = 2'b11; step();
    chk("rst_ready", obs_ready, 2'b00);
    chk("rst_rsp_valid", obs_rv, 2'b00);
    step();
    rst = 1'b0; step();
    chk("post_rst_grant", obs_ready, 2'b01);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 99) < 25) v[i] = ~v[i];
        ad[i] = ($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 15));
        w[i]  = ($urandom_range(0, 2) == 0);
        wd[i] = DW'($urandom);
      end
      rst = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
